// File: rtl/complex_alu_writeback.sv
// rtl/complex_alu_writeback.sv - fixed-latency writeback stage for the complex (mult/div/syscall) ALU
//
// Purpose: captures a complex-ALU result together with its destination tag and
// active-list id. The entry is delayed LATENCY cycles and then presented from an
// in-order FIFO on a valid/ready writeback bus. Issue back-pressure is credit based,
// so the FIFO can never overflow. flush_i squashes everything in flight.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   issue_valid_i/ready issue handshake; issue_tag_i, issue_al_id_i identify the instruction
//   alu_result_i        2*DATA_W result; only the low DATA_W bits are kept
//   alu_flags_i         execution flags, passed through untouched
//   flush_i             recovery squash of pipeline and FIFO
//   wb_valid_o/ready_i  writeback handshake; wb_data/tag/al_id/flags_o come from the FIFO head
//   hi_o, lo_o          HI/LO architectural registers (only with COMPLEX_WB_HILO_EN)
//
// Optional feature macro: COMPLEX_WB_HILO_EN

module complex_alu_writeback #(
    parameter int DATA_W    = 32,
    parameter int FLAG_W    = 6,
    parameter int TAG_W     = 7,
    parameter int ALID_W    = 7,
    parameter int LATENCY   = 3,
    parameter int BUF_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                issue_valid_i,
    output logic                issue_ready_o,
    input  logic [TAG_W-1:0]    issue_tag_i,
    input  logic [ALID_W-1:0]   issue_al_id_i,
    input  logic [2*DATA_W-1:0] alu_result_i,
    input  logic [FLAG_W-1:0]   alu_flags_i,
    input  logic                flush_i,
    output logic                wb_valid_o,
    input  logic                wb_ready_i,
    output logic [DATA_W-1:0]   wb_data_o,
    output logic [TAG_W-1:0]    wb_tag_o,
    output logic [ALID_W-1:0]   wb_al_id_o,
`ifdef COMPLEX_WB_HILO_EN
    output logic [DATA_W-1:0]   hi_o,
    output logic [DATA_W-1:0]   lo_o,
`endif
    output logic [FLAG_W-1:0]   wb_flags_o
);

    localparam int ENTRY_W = DATA_W + TAG_W + ALID_W + FLAG_W;
    localparam int STAGES  = LATENCY - 1;
    localparam int PIPE_N  = (STAGES > 0) ? STAGES : 1;
    localparam int PTR_W   = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W   = $clog2(BUF_DEPTH + LATENCY + 1);

    // Upper half of the ALU result is architecturally discarded here.
    logic unused_result_hi;
    assign unused_result_hi = ^alu_result_i[2*DATA_W-1:DATA_W];

    logic               accept;
    logic [ENTRY_W-1:0] new_e;
    logic               push_v;
    logic [ENTRY_W-1:0] push_e;
    logic               pop;

    logic [PIPE_N-1:0]  pipe_v;
    logic [ENTRY_W-1:0] pipe_e [PIPE_N];

    logic [ENTRY_W-1:0] mem [BUF_DEPTH];
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   pipe_cnt;
    logic [CNT_W-1:0]   inflight;

    assign new_e  = {alu_result_i[DATA_W-1:0], issue_tag_i, issue_al_id_i, alu_flags_i};
    assign accept = issue_valid_i && issue_ready_o && !flush_i;

    // Fixed-latency delay line. It never stalls: credits reserve a FIFO slot for
    // every entry before it is accepted.
    generate
        if (STAGES > 0) begin : g_pipe
            always_ff @(posedge clk) begin
                if (reset || flush_i) begin
                    pipe_v <= '0;
                end else begin
                    pipe_v[0] <= accept;
                    for (int i = 1; i < STAGES; i++) begin
                        pipe_v[i] <= pipe_v[i-1];
                    end
                end
                pipe_e[0] <= new_e;
                for (int i = 1; i < STAGES; i++) begin
                    pipe_e[i] <= pipe_e[i-1];
                end
            end
            assign push_v = pipe_v[PIPE_N-1];
            assign push_e = pipe_e[PIPE_N-1];
        end else begin : g_nopipe
            assign pipe_v    = '0;
            assign pipe_e[0] = '0;
            assign push_v    = accept;
            assign push_e    = new_e;
        end
    endgenerate

    always_comb begin
        pipe_cnt = '0;
        for (int i = 0; i < PIPE_N; i++) begin
            pipe_cnt = pipe_cnt + CNT_W'(pipe_v[i]);
        end
    end

    // Credits are derived only from registered state, so a pop frees its slot
    // for issue starting the following cycle.
    assign inflight      = pipe_cnt + count;
    assign issue_ready_o = (inflight < CNT_W'(BUF_DEPTH));

    assign wb_valid_o = (count != '0);
    assign pop        = wb_valid_o && wb_ready_i;
    assign {wb_data_o, wb_tag_o, wb_al_id_o, wb_flags_o} = mem[head];

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            // Storage is cleared so the head-driven wb_* outputs read zero after reset.
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            assert (!(push_v && !pop && count == CNT_W'(BUF_DEPTH)))
                else $error("complex_alu_writeback: push into full fifo");
            if (push_v) begin
                mem[tail] <= push_e;
                tail      <= ptr_next(tail);
            end
            if (pop) begin
                head <= ptr_next(head);
            end
            if (push_v && !pop) begin
                count <= count + 1'b1;
            end else if (!push_v && pop) begin
                count <= count - 1'b1;
            end
        end
    end

`ifdef COMPLEX_WB_HILO_EN
    // HI/LO update on pop: flag bit4 requests the write, bit3 selects LO,
    // and excepting entries (bit1) never update architectural state.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_o <= '0;
            lo_o <= '0;
        end else if (!flush_i && pop && wb_flags_o[4] && !wb_flags_o[1]) begin
            if (wb_flags_o[3]) begin
                lo_o <= wb_data_o;
            end else begin
                hi_o <= wb_data_o;
            end
        end
    end
`endif

endmodule

// File: tb/tb_complex_alu_writeback.sv
// tb/tb_complex_alu_writeback.sv - directed self-checking bench for complex_alu_writeback

module tb_complex_alu_writeback;

    logic        clk = 1'b0;
    logic        reset;
    logic        issue_valid_i;
    logic        issue_ready_o;
    logic [6:0]  issue_tag_i;
    logic [6:0]  issue_al_id_i;
    logic [63:0] alu_result_i;
    logic [5:0]  alu_flags_i;
    logic        flush_i;
    logic        wb_valid_o;
    logic        wb_ready_i;
    logic [31:0] wb_data_o;
    logic [6:0]  wb_tag_o;
    logic [6:0]  wb_al_id_o;
    logic [5:0]  wb_flags_o;
`ifdef COMPLEX_WB_HILO_EN
    logic [31:0] hi_o;
    logic [31:0] lo_o;
`endif

    int vectors     = 0;
    int miscompares = 0;
    int accepted;

    complex_alu_writeback dut (
        .clk           (clk),
        .reset         (reset),
        .issue_valid_i (issue_valid_i),
        .issue_ready_o (issue_ready_o),
        .issue_tag_i   (issue_tag_i),
        .issue_al_id_i (issue_al_id_i),
        .alu_result_i  (alu_result_i),
        .alu_flags_i   (alu_flags_i),
        .flush_i       (flush_i),
        .wb_valid_o    (wb_valid_o),
        .wb_ready_i    (wb_ready_i),
        .wb_data_o     (wb_data_o),
        .wb_tag_o      (wb_tag_o),
        .wb_al_id_o    (wb_al_id_o),
`ifdef COMPLEX_WB_HILO_EN
        .hi_o          (hi_o),
        .lo_o          (lo_o),
`endif
        .wb_flags_o    (wb_flags_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic set_issue(input logic v, input logic [6:0] tag, input logic [63:0] res, input logic [5:0] flg);
        issue_valid_i = v;
        issue_tag_i   = tag;
        issue_al_id_i = tag + 7'd1;
        alu_result_i  = res;
        alu_flags_i   = flg;
    endtask

    initial begin
        reset = 1'b1;
        flush_i = 1'b0;
        wb_ready_i = 1'b0;
        set_issue(1'b0, 7'd0, 64'd0, 6'd0);
        tick();
        tick();

        // Reset state
        check("rst_wb_valid", 64'(wb_valid_o), 64'd0);
        check("rst_issue_ready", 64'(issue_ready_o), 64'd1);
        check("rst_wb_data", 64'(wb_data_o), 64'd0);
        check("rst_wb_tag", 64'(wb_tag_o), 64'd0);
        check("rst_wb_al_id", 64'(wb_al_id_o), 64'd0);
        check("rst_wb_flags", 64'(wb_flags_o), 64'd0);
`ifdef COMPLEX_WB_HILO_EN
        check("rst_hi", 64'(hi_o), 64'd0);
        check("rst_lo", 64'(lo_o), 64'd0);
`endif
        reset = 1'b0;
        wb_ready_i = 1'b1;
        tick();

        // Single issue: visible exactly in cycle 3, upper result half dropped
        issue_valid_i = 1'b1;
        issue_tag_i   = 7'd5;
        issue_al_id_i = 7'd9;
        alu_result_i  = 64'h0000_0000_FFFF_FFFE;
        alu_flags_i   = 6'h1C;
        check("single_ready_c0", 64'(issue_ready_o), 64'd1);
        tick();
        set_issue(1'b0, 7'd0, 64'hDEAD_BEEF_0000_0000, 6'd0);
        check("single_valid_c1", 64'(wb_valid_o), 64'd0);
        tick();
        check("single_valid_c2", 64'(wb_valid_o), 64'd0);
        tick();
        check("single_valid_c3", 64'(wb_valid_o), 64'd1);
        check("single_data", 64'(wb_data_o), 64'hFFFF_FFFE);
        check("single_tag", 64'(wb_tag_o), 64'd5);
        check("single_al_id", 64'(wb_al_id_o), 64'd9);
        check("single_flags", 64'(wb_flags_o), 64'h1C);
        tick();
        check("single_valid_c4", 64'(wb_valid_o), 64'd0);
`ifdef COMPLEX_WB_HILO_EN
        check("single_lo_written", 64'(lo_o), 64'hFFFF_FFFE);
        check("single_hi_kept", 64'(hi_o), 64'd0);
`endif
        tick();

        // Six back-to-back issues at full throughput
        for (int k = 0; k < 10; k++) begin
            if (k < 6) begin
                set_issue(1'b1, 7'(k + 1), 64'(k + 100), 6'd0);
                check("b2b_issue_ready", 64'(issue_ready_o), 64'd1);
            end else begin
                set_issue(1'b0, 7'd0, 64'd0, 6'd0);
            end
            if (k >= 3 && k <= 8) begin
                check("b2b_wb_valid", 64'(wb_valid_o), 64'd1);
                check("b2b_wb_tag", 64'(wb_tag_o), 64'(k - 2));
                check("b2b_wb_data", 64'(wb_data_o), 64'(k + 97));
            end
            if (k == 9) begin
                check("b2b_drained", 64'(wb_valid_o), 64'd0);
            end
            tick();
        end

        // Back-pressure: only BUF_DEPTH credits available
        wb_ready_i = 1'b0;
        accepted = 0;
        for (int k = 0; k < 8; k++) begin
            set_issue(1'b1, 7'(20 + accepted), 64'(200 + accepted), 6'd0);
            if (issue_ready_o) begin
                accepted++;
            end
            tick();
        end
        set_issue(1'b0, 7'd0, 64'd0, 6'd0);
        check("bp_accepted", 64'(accepted), 64'd4);
        check("bp_issue_ready_low", 64'(issue_ready_o), 64'd0);
        check("bp_hold_valid", 64'(wb_valid_o), 64'd1);
        check("bp_hold_tag", 64'(wb_tag_o), 64'd20);
        tick();
        check("bp_hold_tag_again", 64'(wb_tag_o), 64'd20);
        wb_ready_i = 1'b1;
        check("bp_drain0_tag", 64'(wb_tag_o), 64'd20);
        check("bp_drain0_ready", 64'(issue_ready_o), 64'd0);
        tick();
        check("bp_drain1_tag", 64'(wb_tag_o), 64'd21);
        check("bp_drain1_ready", 64'(issue_ready_o), 64'd1);
        tick();
        check("bp_drain2_tag", 64'(wb_tag_o), 64'd22);
        tick();
        check("bp_drain3_valid", 64'(wb_valid_o), 64'd1);
        check("bp_drain3_tag", 64'(wb_tag_o), 64'd23);
        tick();
        check("bp_drained", 64'(wb_valid_o), 64'd0);
        tick();

        // Flush in cycle 2 squashes everything in flight plus that cycle's issue
        for (int k = 0; k < 3; k++) begin
            set_issue(1'b1, 7'(40 + k), 64'(400 + k), 6'd0);
            flush_i = (k == 2);
            tick();
        end
        set_issue(1'b0, 7'd0, 64'd0, 6'd0);
        flush_i = 1'b0;
        check("flush_issue_ready", 64'(issue_ready_o), 64'd1);
        for (int k = 0; k < 5; k++) begin
            check("flush_no_wb", 64'(wb_valid_o), 64'd0);
            tick();
        end

`ifdef COMPLEX_WB_HILO_EN
        // HI write, then an excepting entry that must not write either register
        set_issue(1'b1, 7'd50, 64'h0000_0000_1234_5678, 6'h14);
        tick();
        set_issue(1'b1, 7'd51, 64'h0000_0000_AAAA_5555, 6'h1E);
        tick();
        set_issue(1'b0, 7'd0, 64'd0, 6'd0);
        tick();
        check("hilo_pop_flags", 64'(wb_flags_o), 64'h14);
        tick();
        check("hilo_hi_written", 64'(hi_o), 64'h1234_5678);
        check("hilo_lo_kept", 64'(lo_o), 64'hFFFF_FFFE);
        check("hilo_exc_pop_valid", 64'(wb_valid_o), 64'd1);
        tick();
        check("hilo_exc_hi_kept", 64'(hi_o), 64'h1234_5678);
        check("hilo_exc_lo_kept", 64'(lo_o), 64'hFFFF_FFFE);
        tick();
`endif

        // Mid-operation reset drops all entries
        set_issue(1'b1, 7'd60, 64'd600, 6'd0);
        tick();
        set_issue(1'b1, 7'd61, 64'd601, 6'd0);
        tick();
        set_issue(1'b0, 7'd0, 64'd0, 6'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_mid_ready", 64'(issue_ready_o), 64'd1);
`ifdef COMPLEX_WB_HILO_EN
        check("rst_mid_hi", 64'(hi_o), 64'd0);
        check("rst_mid_lo", 64'(lo_o), 64'd0);
`endif
        for (int k = 0; k < 4; k++) begin
            check("rst_mid_no_wb", 64'(wb_valid_o), 64'd0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
